// File: rtl/fp_divsqrt_arbiter.sv
// Round-robin sharing of one iterative FP div/sqrt unit among NREQ cores; grant is same-cycle combinational,
// result strobe lands one cycle after the unit's done pulse; requests are held off (no grant) while an op is in flight.
module fp_divsqrt_arbiter #(
    parameter int NREQ       = 4,
    parameter int FP_WIDTH   = 32,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 4,
    parameter int ID_WIDTH   = $clog2(NREQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_i,
    output logic [NREQ-1:0]           gnt_o,
    input  logic [NREQ*FP_WIDTH-1:0]  opa_i,
    input  logic [NREQ*FP_WIDTH-1:0]  opb_i,
    input  logic [NREQ-1:0]           sqrt_i,
    input  logic [NREQ*RND_WIDTH-1:0] rnd_i,
    output logic [NREQ-1:0]           rvalid_o,
    output logic [FP_WIDTH-1:0]       result_o,
    output logic [STAT_WIDTH-1:0]     status_o,
    output logic                      err_o,
    output logic                      unit_en_o,
    output logic [FP_WIDTH-1:0]       unit_opa_o,
    output logic [FP_WIDTH-1:0]       unit_opb_o,
    output logic                      unit_sqrt_o,
    output logic [RND_WIDTH-1:0]      unit_rnd_o,
    input  logic                      unit_ready_i,
    input  logic                      unit_valid_i,
    input  logic [FP_WIDTH-1:0]       unit_res_i,
    input  logic [STAT_WIDTH-1:0]     unit_status_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]         rvalid_q, rvalid_d;
    logic [FP_WIDTH-1:0]     result_q, result_d;
    logic [STAT_WIDTH-1:0]   status_q, status_d;
    logic                    err_q, err_d;

    logic                    win_vld;
    logic [ID_WIDTH-1:0]     win_id;
    logic [ID_WIDTH-1:0]     sel_id;
    logic                    fire;

    logic [FP_WIDTH-1:0]     opa_arr [NREQ];
    logic [FP_WIDTH-1:0]     opb_arr [NREQ];
    logic [RND_WIDTH-1:0]    rnd_arr [NREQ];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            opa_arr[k] = opa_i[k*FP_WIDTH +: FP_WIDTH];
            opb_arr[k] = opb_i[k*FP_WIDTH +: FP_WIDTH];
            rnd_arr[k] = rnd_i[k*RND_WIDTH +: RND_WIDTH];
        end
    end

    // Scan offsets from the far end down so the last hit is the closest one at or after rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[ID_WIDTH'((int'(rr_ptr_q) + i) % NREQ)]) begin
                win_vld = 1'b1;
                win_id  = ID_WIDTH'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    // A start issued during reset would be lost along with the unit's own reset, so suppress it.
    assign fire   = (state_q == IDLE) && win_vld && unit_ready_i && !rst_i;
    assign sel_id = fire ? win_id : '0;

    assign gnt_o       = fire ? (NREQ'(1) << win_id) : '0;
    assign unit_en_o   = fire;
    assign unit_opa_o  = opa_arr[sel_id];
    assign unit_opb_o  = opb_arr[sel_id];
    assign unit_sqrt_o = sqrt_i[sel_id];
    assign unit_rnd_o  = rnd_arr[sel_id];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        rvalid_d = '0;
        result_d = result_q;
        status_d = status_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (unit_valid_i) begin
                    err_d = 1'b1;
                end
                if (fire) begin
                    owner_d  = win_id;
                    rr_ptr_d = (win_id == ID_WIDTH'(NREQ - 1)) ? '0 : win_id + ID_WIDTH'(1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (unit_valid_i) begin
                    result_d = unit_res_i;
                    status_d = unit_status_i;
                    rvalid_d = NREQ'(1) << owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            rvalid_q <= '0;
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            result_q <= result_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign result_o = result_q;
    assign status_o = status_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Bench for fp_divsqrt_arbiter: reset, cycle tables, directed corner sequences, then random traffic vs a model.
module tb_fp_divsqrt_arbiter;
    localparam int NREQ = 4;
    localparam int FPW  = 32;
    localparam int RW   = 3;
    localparam int SW   = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NREQ-1:0]   req_i, gnt_o, sqrt_i, rvalid_o;
    logic [NREQ*FPW-1:0] opa_i, opb_i;
    logic [NREQ*RW-1:0]  rnd_i;
    logic [FPW-1:0]    result_o, unit_opa_o, unit_opb_o, unit_res_i;
    logic [SW-1:0]     status_o, unit_status_i;
    logic              err_o, unit_en_o, unit_sqrt_o, unit_ready_i, unit_valid_i;
    logic [RW-1:0]     unit_rnd_o;

    always #5 clk = ~clk;

    fp_divsqrt_arbiter #(.NREQ(NREQ), .FP_WIDTH(FPW), .RND_WIDTH(RW), .STAT_WIDTH(SW)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .opa_i(opa_i), .opb_i(opb_i), .sqrt_i(sqrt_i), .rnd_i(rnd_i),
        .rvalid_o(rvalid_o), .result_o(result_o), .status_o(status_o), .err_o(err_o),
        .unit_en_o(unit_en_o), .unit_opa_o(unit_opa_o), .unit_opb_o(unit_opb_o),
        .unit_sqrt_o(unit_sqrt_o), .unit_rnd_o(unit_rnd_o), .unit_ready_i(unit_ready_i),
        .unit_valid_i(unit_valid_i), .unit_res_i(unit_res_i), .unit_status_i(unit_status_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       vld;
        logic [3:0] gnt;
        logic       en;
        logic [3:0] rv;
        logic       err;
    } step_t;

    step_t tbl[$];

    task automatic add(input logic [3:0] req, input logic rdy, input logic vld,
                       input logic [3:0] gnt, input logic en, input logic [3:0] rv, input logic err);
        step_t s;
        s = '{req, rdy, vld, gnt, en, rv, err};
        tbl.push_back(s);
    endtask

    task automatic randomize_inputs();
        req_i         = 4'($urandom);
        opa_i         = {$urandom, $urandom, $urandom, $urandom};
        opb_i         = {$urandom, $urandom, $urandom, $urandom};
        sqrt_i        = 4'($urandom);
        rnd_i         = 12'($urandom);
        unit_ready_i  = 1'($urandom);
        unit_valid_i  = 1'($urandom);
        unit_res_i    = $urandom;
        unit_status_i = 4'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference state for the random phase.
    int          m_rr, m_owner, m_cd, k, sel;
    bit          m_busy, m_err;
    logic [31:0] m_res;
    logic [3:0]  m_stat, m_rv, exp_gnt;

    initial begin
        // Reset with random inputs, including a stray unit_valid_i.
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            randomize_inputs();
            next_cycle();
        end
        randomize_inputs();
        unit_ready_i = 1'b1;
        req_i        = 4'hF;
        @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_en", unit_en_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_status", status_o, 0);
        chk("rst_err", err_o, 0);
        next_cycle();
        rst_i = 1'b0;
        for (int c = 0; c < NREQ; c++) begin
            opa_i[c*FPW +: FPW] = 32'h3F80_0000 + 32'(c);
            opb_i[c*FPW +: FPW] = 32'h4000_0000 + 32'(c);
        end
        sqrt_i = 4'b0101;
        rnd_i  = 12'o3210;

        // Cycle tables: round robin, ready gating, spurious valid, withdrawal, wrap.
        add(4'hF,1,0, 4'h1,1, 4'h0,0);
        add(4'hF,1,0, 4'h0,0, 4'h0,0);
        add(4'hF,1,1, 4'h0,0, 4'h0,0);
        add(4'hF,1,0, 4'h2,1, 4'h1,0);
        add(4'hF,1,1, 4'h0,0, 4'h0,0);
        add(4'hF,1,0, 4'h4,1, 4'h2,0);
        add(4'hF,1,1, 4'h0,0, 4'h0,0);
        add(4'hF,1,0, 4'h8,1, 4'h4,0);
        add(4'hF,1,1, 4'h0,0, 4'h0,0);
        add(4'hF,1,0, 4'h1,1, 4'h8,0);
        add(4'hF,1,1, 4'h0,0, 4'h0,0);
        add(4'h0,1,0, 4'h0,0, 4'h1,0);
        for (int c = 0; c < 5; c++) add(4'h2,0,0, 4'h0,0, 4'h0,0);
        add(4'h2,1,0, 4'h2,1, 4'h0,0);
        add(4'h0,1,1, 4'h0,0, 4'h0,0);
        add(4'h0,1,0, 4'h0,0, 4'h2,0);
        add(4'h0,1,1, 4'h0,0, 4'h0,0);
        add(4'h0,1,0, 4'h0,0, 4'h0,1);
        add(4'h8,0,0, 4'h0,0, 4'h0,1);
        add(4'h0,1,0, 4'h0,0, 4'h0,1);
        add(4'h1,1,0, 4'h1,1, 4'h0,1);
        add(4'h0,1,1, 4'h0,0, 4'h0,1);
        add(4'h9,1,0, 4'h8,1, 4'h1,1);
        add(4'h0,1,1, 4'h0,0, 4'h0,1);
        add(4'h9,1,0, 4'h1,1, 4'h8,1);
        add(4'h0,1,1, 4'h0,0, 4'h0,1);
        add(4'h0,1,0, 4'h0,0, 4'h1,1);

        foreach (tbl[i]) begin
            req_i        = tbl[i].req;
            unit_ready_i = tbl[i].rdy;
            unit_valid_i = tbl[i].vld;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].gnt);
            chk($sformatf("tbl%0d_en", i), unit_en_o, tbl[i].en);
            chk($sformatf("tbl%0d_rvalid", i), rvalid_o, tbl[i].rv);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].err);
            next_cycle();
        end

        // Single div from core 2, unit answers 10 cycles after the grant.
        opa_i[2*FPW +: FPW] = 32'h4040_0000;
        opb_i[2*FPW +: FPW] = 32'h3F80_0000;
        sqrt_i       = 4'b1011;
        rnd_i        = 12'o0000;
        rnd_i[2*RW +: RW] = 3'd4;
        req_i        = 4'b0100;
        unit_ready_i = 1'b1;
        unit_valid_i = 1'b0;
        @(negedge clk);
        chk("single_gnt", gnt_o, 4'b0100);
        chk("single_en", unit_en_o, 1);
        chk("single_opa", unit_opa_o, 32'h4040_0000);
        chk("single_opb", unit_opb_o, 32'h3F80_0000);
        chk("single_sqrt", unit_sqrt_o, 0);
        chk("single_rnd", unit_rnd_o, 3'd4);
        next_cycle();
        req_i = 4'b0000;
        repeat (9) next_cycle();
        unit_valid_i  = 1'b1;
        unit_res_i    = 32'h4040_0000;
        unit_status_i = 4'h2;
        req_i         = 4'hF;
        @(negedge clk);
        chk("single_nognt_on_valid", gnt_o, 0);
        chk("single_norv_yet", rvalid_o, 0);
        next_cycle();
        unit_valid_i  = 1'b0;
        unit_res_i    = 32'hFFFF_FFFF;
        unit_status_i = 4'hF;
        req_i         = 4'h0;
        @(negedge clk);
        chk("single_rvalid", rvalid_o, 4'b0100);
        chk("single_result", result_o, 32'h4040_0000);
        chk("single_status", status_o, 4'h2);
        next_cycle();
        @(negedge clk);
        chk("single_rv_pulse", rvalid_o, 0);
        chk("single_result_hold", result_o, 32'h4040_0000);
        next_cycle();

        // Reset in the middle of an op from core 3, then a late valid.
        req_i = 4'b1000;
        @(negedge clk);
        chk("midrst_gnt", gnt_o, 4'b1000);
        next_cycle();
        req_i = 4'h0;
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", rvalid_o, 0);
        chk("midrst_err", err_o, 0);
        next_cycle();
        unit_valid_i = 1'b1;
        unit_res_i   = 32'hDEAD_BEEF;
        next_cycle();
        unit_valid_i = 1'b0;
        req_i        = 4'hF;
        @(negedge clk);
        chk("late_valid_err", err_o, 1);
        chk("late_valid_rvalid", rvalid_o, 0);
        chk("late_valid_result", result_o, 0);
        chk("midrst_first_gnt", gnt_o, 4'b0001);
        next_cycle();

        // Random traffic checked against the behavioural model.
        rst_i = 1'b1;
        req_i = 4'h0;
        repeat (2) next_cycle();
        rst_i  = 1'b0;
        m_rr   = 0; m_owner = 0; m_cd = 0;
        m_busy = 0; m_err = 0;
        m_res  = '0; m_stat = '0; m_rv = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            randomize_inputs();
            unit_ready_i = ($urandom_range(0, 3) != 0);
            if (m_busy) begin
                m_cd--;
                unit_valid_i = (m_cd == 0);
            end else begin
                unit_valid_i = ($urandom_range(0, 49) == 0);
            end
            k = -1;
            if (!m_busy && unit_ready_i) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (k < 0 && req_i[(m_rr + i) % NREQ]) k = (m_rr + i) % NREQ;
                end
            end
            exp_gnt = (k >= 0) ? 4'(1 << k) : 4'h0;
            sel     = (k >= 0) ? k : 0;
            @(negedge clk);
            chk("rnd_gnt", gnt_o, exp_gnt);
            chk("rnd_en", unit_en_o, k >= 0);
            chk("rnd_opa", unit_opa_o, opa_i[sel*FPW +: FPW]);
            chk("rnd_opb", unit_opb_o, opb_i[sel*FPW +: FPW]);
            chk("rnd_sqrt", unit_sqrt_o, sqrt_i[sel]);
            chk("rnd_rnd", unit_rnd_o, rnd_i[sel*RW +: RW]);
            chk("rnd_rvalid", rvalid_o, m_rv);
            chk("rnd_result", result_o, m_res);
            chk("rnd_status", status_o, m_stat);
            chk("rnd_err", err_o, m_err);
            m_rv = '0;
            if (m_busy) begin
                if (unit_valid_i) begin
                    m_res  = unit_res_i;
                    m_stat = unit_status_i;
                    m_rv   = 4'(1 << m_owner);
                    m_busy = 0;
                end
            end else begin
                if (unit_valid_i) m_err = 1;
                if (k >= 0) begin
                    m_owner = k;
                    m_rr    = (k + 1) % NREQ;
                    m_busy  = 1;
                    m_cd    = $urandom_range(1, 6);
                end
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
